// File: rtl/quantser_pkg.sv
// Shared types and constants for the quantser bit-plane collection path.
package quantser_pkg;

    localparam int BDOUTMAX  = 32;
    localparam int QS_N      = 64;
    localparam int QS_BWADDR = 12;

    typedef enum logic [0:0] {
        IDLE,
        COLLECT
    } qcoll_state_t;

    typedef struct packed {
        logic [QS_BWADDR-1:0] addr;
        logic [QS_N-1:0]      data;
    } plane_word_t;

endpackage

// File: rtl/quantser_collector_plane_fifo.sv
// Synchronous FIFO for address-tagged bit-plane words; a pop frees room for a
// push in the same cycle, and the head reads as zero while the FIFO is empty.
module plane_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/quantser_collector.sv
// Packs serialized quantser lane bits into address-tagged bit-plane words and
// buffers them toward activation memory through a valid/ready write port.
module quantser_collector #(
    parameter int N         = 64,
    parameter int BDOUTMAX  = 32,
    parameter int BWADDR    = 12,
    parameter int FIFODEPTH = 4
) (
    input  logic                        clk,
    input  logic                        clr,
    input  logic                        start,
    input  logic [$clog2(BDOUTMAX)-1:0] bdout,
    input  logic [BWADDR-1:0]           baseaddr,
    input  logic [N-1:0]                sin,
    output logic                        wrvalid,
    input  logic                        wrready,
    output logic [N-1:0]                wrdata,
    output logic [BWADDR-1:0]           wraddr,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        ovf
);

    import quantser_pkg::*;

    localparam int BW = $clog2(BDOUTMAX);
    localparam int FW = BWADDR + N;

    qcoll_state_t      state;
    qcoll_state_t      state_nxt;
    logic [BW-1:0]     planeidx;
    logic [BW-1:0]     nplanes_m1;
    logic [BWADDR-1:0] base;
    logic              last;
    logic              push;
    logic              accept;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     push_word;
    logic [FW-1:0]     head_word;

    assign accept    = (state == IDLE) && start;
    assign push      = (state == COLLECT);
    assign last      = (planeidx == nplanes_m1);
    // Address wraps modulo 2^BWADDR by construction of the adder width.
    assign push_word = {base + BWADDR'(planeidx), sin};
    assign drop      = push && fifo_full && !(wrready && !fifo_empty);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            planeidx <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= push && last;
            if (start && state == COLLECT) err <= 1'b1;
            if (drop) ovf <= 1'b1;
            // Dropped words still consume their plane slot.
            if (accept)             planeidx <= '0;
            else if (push && !last) planeidx <= planeidx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            nplanes_m1 <= bdout;
            base       <= baseaddr;
        end
    end

    plane_fifo #(
        .W     (FW),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (push),
        .pop   (wrready),
        .wdata (push_word),
        .rdata (head_word),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wrvalid          = !fifo_empty;
    assign {wraddr, wrdata} = head_word;
    assign busy             = (state == COLLECT);

endmodule

// File: tb/tb_quantser_collector.sv
// Scoreboard bench for quantser_collector: expected words are queued as planes are driven.
module tb_quantser_collector;

    import quantser_pkg::*;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [4:0]  bdout;
    logic [11:0] baseaddr;
    logic [63:0] sin;
    logic        wrvalid;
    logic        wrready;
    logic [63:0] wrdata;
    logic [11:0] wraddr;
    logic        busy;
    logic        done;
    logic        err;
    logic        ovf;

    plane_word_t q[$];
    plane_word_t exp_word;
    logic [63:0] pat [32];
    int nvec  = 0;
    int nerr  = 0;
    int pops  = 0;
    int dones = 0;
    int p0;
    int d0;

    always #5 clk = ~clk;

    quantser_collector #(
        .N         (64),
        .BDOUTMAX  (32),
        .BWADDR    (12),
        .FIFODEPTH (4)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .bdout    (bdout),
        .baseaddr (baseaddr),
        .sin      (sin),
        .wrvalid  (wrvalid),
        .wrready  (wrready),
        .wrdata   (wrdata),
        .wraddr   (wraddr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ovf      (ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, got, want);
        end
    endtask

    // Handshakes are observed at the falling edge; the pop lands on the next rising edge.
    always @(negedge clk) begin
        if (!clr) begin
            if (done) dones++;
            if (wrvalid && wrready) begin
                pops++;
                if (q.size() == 0) begin
                    check_eq("spurious_word", 64'(wrvalid), 64'd0);
                end else begin
                    exp_word = q.pop_front();
                    check_eq("wraddr", 64'(wraddr), 64'(exp_word.addr));
                    check_eq("wrdata", wrdata, exp_word.data);
                end
            end
        end
    end

    task automatic randpat();
        for (int i = 0; i < 32; i++) pat[i] = {$urandom(), $urandom()};
    endtask

    task automatic job(input logic [4:0] b, input logic [11:0] base, input int nexp,
                       input int rdy_at, input int err_at, input bit lat);
        start    = 1'b1;
        bdout    = b;
        baseaddr = base;
        @(posedge clk); #1;
        start = 1'b0;
        for (int p = 0; p <= int'(b); p++) begin
            sin = pat[p];
            if (p == rdy_at) wrready = 1'b1;
            if (p == err_at) begin
                start    = 1'b1;
                baseaddr = 12'h777;
                bdout    = 5'd9;
            end
            if (p < nexp) q.push_back('{addr: base + 12'(p), data: pat[p]});
            if (p == 0) check_eq("busy_start", 64'(busy), 64'd1);
            @(posedge clk); #1;
            start = 1'b0;
            if (p == 0 && lat) begin
                check_eq("lat_wrvalid", 64'(wrvalid), 64'd1);
                check_eq("lat_wraddr", 64'(wraddr), 64'(base));
            end
        end
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("busy_end", 64'(busy), 64'd0);
    endtask

    task automatic drain();
        wrready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (q.size() == 0 && !wrvalid) break;
            @(posedge clk); #1;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        check_eq("drain_queue", 64'(q.size()), 64'd0);
        check_eq("drain_wrvalid", 64'(wrvalid), 64'd0);
    endtask

    task automatic clr_pulse();
        #2 clr = 1'b1;
        #1;
        check_eq("clr_err", 64'(err), 64'd0);
        check_eq("clr_ovf", 64'(ovf), 64'd0);
        q.delete();
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b0;
        bdout    = '0;
        baseaddr = '0;
        sin      = '0;
        wrready  = 1'b0;
        #12;
        check_eq("rst_wrvalid", 64'(wrvalid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_wrdata", wrdata, 64'd0);
        check_eq("rst_wraddr", 64'(wraddr), 64'd0);
        @(posedge clk); #1;
        clr = 1'b0;

        // Asynchronous clear mid-collection with two words buffered.
        randpat();
        start = 1'b1; bdout = 5'd7; baseaddr = 12'h100;
        @(posedge clk); #1;
        start = 1'b0; sin = pat[0];
        @(posedge clk); #1;
        sin = pat[1];
        @(posedge clk); #1;
        check_eq("mid_wrvalid", 64'(wrvalid), 64'd1);
        check_eq("mid_busy", 64'(busy), 64'd1);
        #2 clr = 1'b1;
        #1;
        check_eq("aclr_wrvalid", 64'(wrvalid), 64'd0);
        check_eq("aclr_busy", 64'(busy), 64'd0);
        check_eq("aclr_done", 64'(done), 64'd0);
        check_eq("aclr_wrdata", wrdata, 64'd0);
        check_eq("aclr_wraddr", 64'(wraddr), 64'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        @(posedge clk); #1;
        check_eq("post_clr_busy", 64'(busy), 64'd0);
        check_eq("post_clr_wrvalid", 64'(wrvalid), 64'd0);

        // Single job with ready held high.
        pat[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        pat[1] = 64'h0000_0000_0000_0000;
        pat[2] = 64'hAAAA_AAAA_AAAA_AAAA;
        pat[3] = 64'h5555_5555_5555_5555;
        wrready = 1'b1;
        p0 = pops; d0 = dones;
        job(5'd3, 12'h010, 4, -1, -1, 1'b1);
        drain();
        check_eq("single_words", 64'(pops - p0), 64'd4);
        check_eq("single_dones", 64'(dones - d0), 64'd1);

        // FIFO full, but a pop in the same cycle makes room.
        randpat();
        wrready = 1'b0;
        p0 = pops;
        job(5'd7, 12'h300, 8, 4, -1, 1'b0);
        check_eq("fullpop_ovf", 64'(ovf), 64'd0);
        drain();
        check_eq("fullpop_words", 64'(pops - p0), 64'd8);

        // Back-pressure: only the first FIFODEPTH words survive.
        randpat();
        wrready = 1'b0;
        p0 = pops;
        job(5'd7, 12'h200, 4, -1, -1, 1'b0);
        check_eq("bp_ovf", 64'(ovf), 64'd1);
        check_eq("bp_wrvalid", 64'(wrvalid), 64'd1);
        check_eq("bp_head_addr", 64'(wraddr), 64'h200);
        drain();
        check_eq("bp_words", 64'(pops - p0), 64'd4);
        clr_pulse();

        // Start while busy is flagged and ignored.
        randpat();
        wrready = 1'b1;
        p0 = pops;
        job(5'd3, 12'h040, 4, -1, 1, 1'b0);
        check_eq("busy_start_err", 64'(err), 64'd1);
        drain();
        check_eq("busy_start_words", 64'(pops - p0), 64'd4);

        // Address wrap and single-plane job.
        randpat();
        p0 = pops;
        job(5'd3, 12'hFFE, 4, -1, -1, 1'b1);
        drain();
        check_eq("wrap_words", 64'(pops - p0), 64'd4);
        randpat();
        p0 = pops;
        job(5'd0, 12'h555, 1, -1, -1, 1'b1);
        drain();
        check_eq("one_plane_words", 64'(pops - p0), 64'd1);
        clr_pulse();

        // Two full-precision jobs back to back.
        p0 = pops; d0 = dones;
        randpat();
        job(5'd31, 12'h800, 32, -1, -1, 1'b0);
        randpat();
        job(5'd31, 12'h900, 32, -1, -1, 1'b0);
        check_eq("b2b_err", 64'(err), 64'd0);
        check_eq("b2b_ovf", 64'(ovf), 64'd0);
        drain();
        check_eq("b2b_words", 64'(pops - p0), 64'd64);
        check_eq("b2b_dones", 64'(dones - d0), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
